// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings and helpers for the load/store memory
//               controller: access sizes, FSM state codes, lane-select width
//               and the request error check.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte-lane select width (offset inside a 32-bit word)
    localparam int c_LANE_SEL_W = 2;

    // FSM state encoding
    localparam int c_STATE_W = 3;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_RD     = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_WR     = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_RMW_RD = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_RMW_WR = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_RESP   = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_ERR    = 3'd6;

    // A request is rejected when misaligned for its size, when it uses the
    // reserved size code, or when its word index falls outside the memory.
    function automatic logic lsu_req_err(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [31:0] depth
    );
        logic bad_align;
        case (size)
            SZ_BYTE: bad_align = 1'b0;
            SZ_HALF: bad_align = addr[0];
            SZ_WORD: bad_align = (addr[1:0] != 2'b00);
            default: bad_align = 1'b1;
        endcase
        return bad_align || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational little-endian lane logic. Extracts and
//               zero/sign-extends the addressed byte/halfword of a loaded
//               word, and merges store data into the addressed lanes of the
//               current memory word for read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]              i_size,
    input  logic [c_LANE_SEL_W-1:0] i_offset,
    input  logic                    i_zero_ext,
    input  logic [31:0]             i_rdata,
    input  logic [15:0]             i_wdata,
    output logic [31:0]             o_load_data,
    output logic [31:0]             o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Load path: pick the addressed lane(s) and extend to 32 bits
    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SZ_BYTE: o_load_data = {{24{~i_zero_ext & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{~i_zero_ext & w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    // Store path: each lane either keeps the memory byte or takes store data.
    // A halfword feeds its low byte to the even lane and high byte to the odd.
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            localparam logic [1:0] c_K = k;
            logic       w_hit;
            logic [7:0] w_src;
            assign w_hit = ((i_size == SZ_BYTE) && (i_offset == c_K)) ||
                           ((i_size == SZ_HALF) && (i_offset[1] == c_K[1]));
            assign w_src = ((i_size == SZ_HALF) && c_K[0]) ? i_wdata[15:8] : i_wdata[7:0];
            assign o_merge_data[8*k+7:8*k] = w_hit ? w_src : i_rdata[8*k+7:8*k];
        end
    endgenerate

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store initiator between the datapath and a
//               word-addressed data memory. One byte/halfword/word request per
//               valid/ready transaction; sub-word stores are done as
//               read-modify-write; misaligned/reserved/out-of-range requests
//               complete with an error and no memory cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH = 100
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] c_DEPTH = 32'(DEPTH);

    logic [c_STATE_W-1:0] r_state;
    logic                 r_we;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_merge;
    logic [31:0]          r_rdata;

    logic                 w_req_err;
    logic [31:0]          w_load_data;
    logic [31:0]          w_merge_data;

    assign w_req_err = lsu_req_err(req_size, req_addr, c_DEPTH);

    lsu_lane_align u_align (
        .i_size       (r_size),
        .i_offset     (r_addr[1:0]),
        .i_zero_ext   (r_unsigned),
        .i_rdata      (mem_rdata),
        .i_wdata      (r_wdata[15:0]),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // FSM and request/response registers
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= c_ST_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_merge    <= 32'h0;
            r_rdata    <= 32'h0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (w_req_err) begin
                            // Error response shows zero data in its own cycle
                            r_rdata <= 32'h0;
                            r_state <= c_ST_ERR;
                        end else if (!req_we) begin
                            r_state <= c_ST_RD;
                        end else if (req_size == SZ_WORD) begin
                            r_state <= c_ST_WR;
                        end else begin
                            r_state <= c_ST_RMW_RD;
                        end
                    end
                end
                c_ST_RMW_RD: begin
                    r_merge <= w_merge_data;
                    r_state <= c_ST_RMW_WR;
                end
                c_ST_RD, c_ST_WR, c_ST_RMW_WR: begin
                    // Final memory cycle: loads capture data, stores clear it
                    r_rdata <= r_we ? 32'h0 : w_load_data;
                    r_state <= c_ST_RESP;
                end
                c_ST_RESP, c_ST_ERR: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state; reset gates the write strobe immediately
    always_comb begin
        req_ready  = (r_state == c_ST_IDLE);
        resp_valid = (r_state == c_ST_RESP) || (r_state == c_ST_ERR);
        resp_err   = (r_state == c_ST_ERR);
        resp_rdata = r_rdata;
        mem_addr   = {2'b00, r_addr[31:2]};
        mem_we     = ((r_state == c_ST_WR) || (r_state == c_ST_RMW_WR)) && !RST;
        case (r_state)
            c_ST_WR:     mem_wdata = r_wdata;
            c_ST_RMW_WR: mem_wdata = r_merge;
            default:     mem_wdata = 32'h0;
        endcase
    end

endmodule : lsu_mem_ctrl
`default_nettype wire
